// File: rtl/uvmt_axis_st_pkt_tx_pkg.sv
// Shared types and constants for the AXI-Stream packet transmitter.
package uvmt_axis_st_pkt_tx_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    // Throttle LFSR: x^16+x^14+x^13+x^11+1, shifting left, taps on bits 15/13/12/10.
    localparam logic [15:0] LFSR_RESET = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    // tkeep of the final beat: lanes 0..r-1 with r = len % data_bytes, r = 0 meaning all lanes.
    // Supports up to 16 lanes; callers slice the low data_bytes bits.
    function automatic logic [15:0] final_keep(input int unsigned len,
                                               input int unsigned data_bytes);
        int unsigned r;
        logic [16:0] ones;
        r = len % data_bytes;
        if (r == 0) r = data_bytes;
        ones = (17'd1 << r) - 17'd1;
        return ones[15:0];
    endfunction

endpackage

// File: rtl/uvmt_axis_st_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to insert tvalid bubbles.
module uvmt_axis_st_lfsr16
    import uvmt_axis_st_pkt_tx_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic        feedback;

    assign feedback = ^(lfsr_q & LFSR_TAPS);
    assign lfsr     = lfsr_q;

    // Advance every cycle; synchronous reset to the seed value.
    always_ff @(posedge clk) begin
        if (!reset_n) lfsr_q <= LFSR_RESET;
        else          lfsr_q <= {lfsr_q[14:0], feedback};
    end

endmodule

// File: rtl/uvmt_axis_st_pkt_tx.sv
// AXI-Stream packet transmitter: one command in, a deterministic byte pattern out
// (byte i = seed + i) with tkeep/tlast framing and full tready backpressure.
// Optional random bubbles before each beat when UVMT_AXIS_ST_PKT_TX_THROTTLE_EN is defined.
module uvmt_axis_st_pkt_tx
    import uvmt_axis_st_pkt_tx_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned DEST_W     = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic [7:0]              cmd_seed,
    input  logic [ID_W-1:0]         cmd_id,
    input  logic [DEST_W-1:0]       cmd_dest,
    output logic                    tvalid,
    input  logic                    tready,
    output logic [8*DATA_BYTES-1:0] tdata,
    output logic [DATA_BYTES-1:0]   tkeep,
    output logic [DATA_BYTES-1:0]   tstrb,
    output logic                    tlast,
    output logic [ID_W-1:0]         tid,
    output logic [DEST_W-1:0]       tdest,
    output logic                    busy,
    output logic                    done
);

    localparam logic [DATA_BYTES-1:0] KEEP_ALL = {DATA_BYTES{1'b1}};

    state_e                  state_q, state_d;
    logic                    rdy_q;
    logic [7:0]              seed_q, seed_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        off_q, off_d;
    logic [LEN_W-1:0]        beats_left_q, beats_left_d;
    logic                    tvalid_q, tvalid_d;
    logic [8*DATA_BYTES-1:0] tdata_q, tdata_d;
    logic [DATA_BYTES-1:0]   tkeep_q, tkeep_d;
    logic                    tlast_q, tlast_d;
    logic [ID_W-1:0]         tid_q, tid_d;
    logic [DEST_W-1:0]       tdest_q, tdest_d;
    logic                    done_q, done_d;

    logic [LEN_W-1:0]        beats;
    logic [LEN_W-1:0]        off_n;
    logic [LEN_W-1:0]        beats_left_n;
    logic [15:0]             fk_full;
    logic [DATA_BYTES-1:0]   keep_n;
    logic                    last_n;
    logic                    bubble;

`ifdef UVMT_AXIS_ST_PKT_TX_THROTTLE_EN
    logic [15:0] lfsr;

    uvmt_axis_st_lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .lfsr    (lfsr)
    );

    assign bubble = (lfsr[1:0] == 2'b00);
`else
    assign bubble = 1'b0;
`endif

    // Payload of a beat starting at byte offset off; unkept lanes are zero.
    function automatic logic [8*DATA_BYTES-1:0] beat_data(input logic [7:0]            seed,
                                                          input logic [LEN_W-1:0]      off,
                                                          input logic [DATA_BYTES-1:0] keep);
        logic [8*DATA_BYTES-1:0] d;
        logic [7:0]              base;
        d    = '0;
        base = seed + off[7:0];
        for (int j = 0; j < DATA_BYTES; j++) begin
            if (keep[j]) d[8*j +: 8] = base + 8'(j);
        end
        return d;
    endfunction

    assign cmd_ready = rdy_q && (state_q == StIdle);
    assign busy      = (state_q == StSend);
    assign done      = done_q;
    assign tvalid    = tvalid_q;
    assign tdata     = tdata_q;
    assign tkeep     = tkeep_q;
    assign tstrb     = tkeep_q;
    assign tlast     = tlast_q;
    assign tid       = tid_q;
    assign tdest     = tdest_q;

    // Next-state: command accept, beat preparation and advance on transfer.
    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        len_d        = len_q;
        off_d        = off_q;
        beats_left_d = beats_left_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tlast_d      = tlast_q;
        tid_d        = tid_q;
        tdest_d      = tdest_q;
        done_d       = 1'b0;
        beats        = LEN_W'(cmd_len / DATA_BYTES) + LEN_W'((cmd_len % DATA_BYTES) != 0);
        off_n        = '0;
        beats_left_n = '0;
        fk_full      = '0;
        keep_n       = KEEP_ALL;
        last_n       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    seed_d  = cmd_seed;
                    len_d   = cmd_len;
                    tid_d   = cmd_id;
                    tdest_d = cmd_dest;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = StSend;
                        off_d        = '0;
                        beats_left_d = beats;
                        last_n       = (beats == LEN_W'(1));
                        fk_full      = final_keep(32'(cmd_len), DATA_BYTES);
                        keep_n       = last_n ? fk_full[DATA_BYTES-1:0] : KEEP_ALL;
                        tkeep_d      = keep_n;
                        tdata_d      = beat_data(cmd_seed, '0, keep_n);
                        tlast_d      = last_n;
                        tvalid_d     = !bubble;
                    end
                end
            end
            StSend: begin
                if (tvalid_q && tready) begin
                    if (tlast_q) begin
                        state_d  = StIdle;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        // Offset only advances on non-final beats, so it never wraps.
                        off_n        = off_q + LEN_W'(DATA_BYTES);
                        beats_left_n = beats_left_q - LEN_W'(1);
                        last_n       = (beats_left_n == LEN_W'(1));
                        fk_full      = final_keep(32'(len_q), DATA_BYTES);
                        keep_n       = last_n ? fk_full[DATA_BYTES-1:0] : KEEP_ALL;
                        off_d        = off_n;
                        beats_left_d = beats_left_n;
                        tkeep_d      = keep_n;
                        tdata_d      = beat_data(seed_q, off_n, keep_n);
                        tlast_d      = last_n;
                        tvalid_d     = !bubble;
                    end
                end else if (!tvalid_q) begin
                    // Beat is prepared but held back by a bubble; retry each cycle.
                    tvalid_d = !bubble;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            rdy_q        <= 1'b0;
            seed_q       <= '0;
            len_q        <= '0;
            off_q        <= '0;
            beats_left_q <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tlast_q      <= 1'b0;
            tid_q        <= '0;
            tdest_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdy_q        <= 1'b1;
            seed_q       <= seed_d;
            len_q        <= len_d;
            off_q        <= off_d;
            beats_left_q <= beats_left_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tlast_q      <= tlast_d;
            tid_q        <= tid_d;
            tdest_q      <= tdest_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_uvmt_axis_st_pkt_tx.sv
// Self-checking bench for uvmt_axis_st_pkt_tx (DATA_BYTES = 4).
module tb_uvmt_axis_st_pkt_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic [7:0]  cmd_seed;
    logic [7:0]  cmd_id;
    logic [3:0]  cmd_dest;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic [3:0]  tstrb;
    logic        tlast;
    logic [7:0]  tid;
    logic [3:0]  tdest;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;

    logic [31:0] exp_data[$];
    logic [3:0]  exp_keep[$];
    bit          exp_last[$];

    uvmt_axis_st_pkt_tx #(
        .DATA_BYTES (4),
        .LEN_W      (16),
        .ID_W       (8),
        .DEST_W     (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_seed  (cmd_seed),
        .cmd_id    (cmd_id),
        .cmd_dest  (cmd_dest),
        .tvalid    (tvalid),
        .tready    (tready),
        .tdata     (tdata),
        .tkeep     (tkeep),
        .tstrb     (tstrb),
        .tlast     (tlast),
        .tid       (tid),
        .tdest     (tdest),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the packet as a flat byte string, byte i = seed + i, cut into 4-byte beats.
    task automatic build(input int len, input logic [7:0] seed);
        logic [31:0] d;
        logic [3:0]  kp;
        int          i;
        exp_data.delete();
        exp_keep.delete();
        exp_last.delete();
        for (int b = 0; b * 4 < len; b++) begin
            d  = '0;
            kp = '0;
            for (int l = 0; l < 4; l++) begin
                i = b * 4 + l;
                if (i < len) begin
                    d[8*l +: 8] = 8'(seed + i);
                    kp[l]       = 1'b1;
                end
            end
            exp_data.push_back(d);
            exp_keep.push_back(kp);
            exp_last.push_back((b + 1) * 4 >= len);
        end
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // Issue one command from a negedge and follow the packet to its done cycle.
    task automatic run_pkt(input int len, input logic [7:0] seed, input logic [7:0] id,
                           input logic [3:0] dest, input int mode);
        int   cyc;
        int   k;
        int   nb;
        int   budget;
        bit   was_valid;
        logic r;
        build(len, seed);
        nb        = exp_data.size();
        budget    = nb * 30 + 50;
        cmd_len   = 16'(len);
        cmd_seed  = seed;
        cmd_id    = id;
        cmd_dest  = dest;
        cmd_valid = 1'b1;
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (len == 0) begin
            check("zero_len_tvalid", tvalid, 1'b0);
            check("zero_len_done", done, 1'b1);
            check("zero_len_busy", busy, 1'b0);
            @(negedge clk);
            check("zero_len_done_pulse", done, 1'b0);
            return;
        end
        k         = 0;
        cyc       = 0;
        was_valid = 1'b0;
        while (k < nb && cyc < budget) begin
            if (tvalid !== 1'b1) begin
`ifdef UVMT_AXIS_ST_PKT_TX_THROTTLE_EN
                check("tvalid_no_drop", was_valid, 1'b0);
`else
                check("tvalid_stream", tvalid, 1'b1);
`endif
                was_valid = 1'b0;
                tready    = pick_ready(mode, cyc);
            end else begin
                check("tdata", tdata, exp_data[k]);
                check("tkeep", tkeep, exp_keep[k]);
                check("tstrb", tstrb, exp_keep[k]);
                check("tlast", tlast, exp_last[k]);
                check("tid", tid, id);
                check("tdest", tdest, dest);
                check("busy_in_flight", busy, 1'b1);
                check("done_in_flight", done, 1'b0);
                r         = pick_ready(mode, cyc);
                tready    = r;
                was_valid = !r;
                if (r) k++;
            end
            @(negedge clk);
            cyc++;
        end
        tready = 1'b0;
        check("beat_count", k, nb);
        check("done_after_last", done, 1'b1);
        check("tvalid_after_last", tvalid, 1'b0);
        check("busy_after_last", busy, 1'b0);
        check("cmd_ready_in_done", cmd_ready, 1'b1);
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_seed  = '0;
        cmd_id    = '0;
        cmd_dest  = '0;
        tready    = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tdata", tdata, 32'h0);
        check("rst_tkeep", tkeep, 4'h0);
        check("rst_tstrb", tstrb, 4'h0);
        check("rst_tid", tid, 8'h0);
        check("rst_tdest", tdest, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_release", cmd_ready, 1'b1);

        // Directed packets.
        run_pkt(8, 8'h10, 8'hA5, 4'h3, 0);
        check("dir_len8_beat0", exp_data[0], 32'h13121110);
        run_pkt(5, 8'hFE, 8'h01, 4'h7, 0);
        check("dir_len5_beat1", exp_data[1], 32'h00000002);
        run_pkt(12, 8'h40, 8'h5C, 4'hC, 1);

        // Zero-length command, then a held command accepted in the done cycle.
        cmd_len   = 16'd0;
        cmd_seed  = 8'h77;
        cmd_id    = 8'h11;
        cmd_dest  = 4'h2;
        cmd_valid = 1'b1;
        check("z_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        check("z_done", done, 1'b1);
        check("z_tvalid", tvalid, 1'b0);
        check("z_busy", busy, 1'b0);
        check("z_cmd_ready_done_cycle", cmd_ready, 1'b1);
        cmd_len  = 16'd4;
        cmd_seed = 8'h20;
        build(4, 8'h20);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_tvalid", tvalid, 1'b1);
        check("b2b_tdata", tdata, exp_data[0]);
        check("b2b_tkeep", tkeep, exp_keep[0]);
        check("b2b_tlast", tlast, 1'b1);
        tready = 1'b1;
        @(negedge clk);
        tready = 1'b0;
        check("b2b_done", done, 1'b1);
        check("b2b_tvalid_after", tvalid, 1'b0);

        // Reset during beat 2 of a 16-byte packet.
        build(16, 8'h33);
        cmd_len   = 16'd16;
        cmd_seed  = 8'h33;
        cmd_id    = 8'h99;
        cmd_dest  = 4'h9;
        cmd_valid = 1'b1;
        tready    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rm_beat0", tdata, exp_data[0]);
        @(negedge clk);
        check("rm_beat1", tdata, exp_data[1]);
        reset_n = 1'b0;
        @(negedge clk);
        tready = 1'b0;
        check("rm_tvalid", tvalid, 1'b0);
        check("rm_busy", busy, 1'b0);
        check("rm_tdata", tdata, 32'h0);
        check("rm_tid", tid, 8'h0);
        check("rm_cmd_ready", cmd_ready, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rm_cmd_ready_release", cmd_ready, 1'b1);
        run_pkt(4, 8'hC0, 8'h42, 4'h5, 0);

        // Randomized packets with random backpressure.
        for (int n = 0; n < 24; n++) begin
            run_pkt(int'($urandom_range(0, 40)), 8'($urandom), 8'($urandom), 4'($urandom), 2);
        end

        // Maximum length: offset must not overflow.
        run_pkt(65535, 8'h5A, 8'hEE, 4'hF, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
